// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: opcodes, functs, ALU ops and FSM states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_NOR = 6'd39;
    localparam logic [5:0] FN_SLT = 6'd42;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } mc_state_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, r0 reads as zero.
module mc_regfile (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_b_o
);

    logic [31:0] rf_q [0:31];

    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i != 5'd0)) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : rf_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : rf_q[raddr_b_i];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core with one shared req/ready memory port and a sticky illegal-opcode trap.
// Define MIPS_MC_PERF_CNT_EN to build the cycle/instret performance counters.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic              trap,
    output logic [2:0]        state_dbg,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret_cnt
);

    mc_state_t   state_q;
    logic [31:0] pc_q, ir_q, a_q, b_q, aluout_q, mdr_q;
    logic        trap_q;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sx, alu_b, alu_res, rf_a, rf_b, rf_wdata, addr_full;
    logic [4:0]  rf_waddr;
    logic        rf_we, funct_ok, mem_active;
    logic [ADDR_W-1:0] addr_sel;
    alu_op_t     alu_op;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];
    assign imm_sx = sext16(ir_q[15:0]);

    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_NOR: return ~(a | b);
            ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
            default: return a + b;
        endcase
    endfunction

    always_comb begin
        alu_op   = ALU_ADD;
        funct_ok = 1'b1;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  alu_op = ALU_ADD;
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_NOR:  alu_op = ALU_NOR;
                FN_SLT:  alu_op = ALU_SLT;
                default: funct_ok = 1'b0;
            endcase
        end
    end

    assign alu_b   = (opcode == OP_RTYPE) ? b_q : imm_sx;
    assign alu_res = alu(alu_op, a_q, alu_b);

    // The port is decoded from the registered state so a request is live on the first FETCH cycle after reset.
    assign mem_active = !reset && ((state_q == ST_FETCH) || (state_q == ST_MEM));
    assign addr_full  = (state_q == ST_MEM) ? aluout_q : pc_q;
    always_comb begin
        addr_sel      = addr_full[ADDR_W-1:0];
        addr_sel[1:0] = 2'b00;
    end
    assign mem_req   = mem_active;
    assign mem_we    = mem_active && (state_q == ST_MEM) && (opcode == OP_SW);
    assign mem_addr  = mem_active ? addr_sel : '0;
    assign mem_wdata = mem_we ? b_q : 32'd0;

    assign rf_we    = !reset && (state_q == ST_WB);
    assign rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
    assign rf_wdata = (opcode == OP_LW) ? mdr_q : aluout_q;

    mc_regfile u_regfile (
        .clk_i     (clock),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (rs),
        .rdata_a_o (rf_a),
        .raddr_b_i (rt),
        .rdata_b_o (rf_b)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
            mdr_q    <= 32'd0;
            trap_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: if (mem_ready) begin
                    ir_q    <= mem_rdata;
                    pc_q    <= pc_q + 32'd4;
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    a_q     <= rf_a;
                    b_q     <= rf_b;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (opcode)
                        OP_RTYPE: begin
                            aluout_q <= alu_res;
                            state_q  <= funct_ok ? ST_WB : ST_TRAP;
                            trap_q   <= !funct_ok;
                        end
                        OP_ADDI: begin
                            aluout_q <= alu_res;
                            state_q  <= ST_WB;
                        end
                        OP_LW, OP_SW: begin
                            aluout_q <= alu_res;
                            state_q  <= ST_MEM;
                        end
                        OP_BEQ: begin
                            // pc already points past the branch, so the offset is relative to pc+4.
                            if (a_q == b_q) pc_q <= pc_q + {imm_sx[29:0], 2'b00};
                            state_q <= ST_FETCH;
                        end
                        OP_J: begin
                            pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
                            state_q <= ST_FETCH;
                        end
                        default: begin
                            state_q <= ST_TRAP;
                            trap_q  <= 1'b1;
                        end
                    endcase
                end
                ST_MEM: if (mem_ready) begin
                    if (opcode == OP_LW) begin
                        mdr_q   <= mem_rdata;
                        state_q <= ST_WB;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_WB:   state_q <= ST_FETCH;
                ST_TRAP: state_q <= ST_TRAP;
                default: begin
                    state_q <= ST_TRAP;
                    trap_q  <= 1'b1;
                end
            endcase
        end
    end

    assign pc        = pc_q;
    assign trap      = trap_q;
    assign state_dbg = state_q;

`ifdef MIPS_MC_PERF_CNT_EN
    logic [31:0] cycle_q, instret_q;
    logic        retire;

    assign retire = (state_q == ST_WB)
                 || ((state_q == ST_EXEC) && ((opcode == OP_BEQ) || (opcode == OP_J)))
                 || ((state_q == ST_MEM) && mem_ready && (opcode == OP_SW));

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            if (state_q != ST_TRAP) cycle_q <= cycle_q + 32'd1;
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = 32'd0;
    assign instret_cnt = 32'd0;
`endif

endmodule
